// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux.
// One request in flight; response returned over valid/ready.
module regfile_read_arbiter #(
  parameter int NREQ  = 4,
  parameter int width = 32,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*5-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  output logic [4:0]        sel,
  input  logic [width-1:0]  mux_result,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [width-1:0]  rsp_data,
  input  logic              rsp_ready
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_nxt;
  logic [4:0]       sel_q;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   win;
  logic             found;
  logic             gnt_en;
  logic             grant;
  int               idx;

  // Winner search from ptr; descending k leaves the nearest hit.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign ptr_nxt = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
  assign sel     = sel_q;

  // Grant window, one-hot grant and next-state selection.
  always_comb begin
    state_d   = state;
    req_ready = '0;
    grant     = 1'b0;
    gnt_en    = (state == IDLE) ||
                (state == RESP && rsp_ready);
    if (gnt_en && found && !rst) begin
      req_ready[win] = 1'b1;
      grant          = 1'b1;
    end
    unique case (state)
      IDLE: if (grant) state_d = READ;
      READ: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = grant ? READ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Request capture and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      sel_q     <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (grant) begin
        sel_q <= req_addr[5*int'(win) +: 5];
        id_q  <= win;
        ptr   <= ptr_nxt;
      end
      if (state == READ) begin
        rsp_data  <= (sel_q == 5'd0) ? '0 : mux_result;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter.
// Register file modelled as a small lookup on sel.
module tb_regfile_read_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [3:0]  req_ready;
  logic [4:0]  sel;
  logic [31:0] mux_result;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_ready;

  logic [31:0] mem [32];
  int          nvec;
  int          nbad;

  regfile_read_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .sel        (sel),
    .mux_result (mux_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file read mux model.
  always_comb mux_result = mem[sel];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [4:0] a);
    req_addr[5*i +: 5] = a;
  endtask

  initial begin
    nvec = 0;
    nbad = 0;
    for (int i = 0; i < 32; i++)
      mem[i] = 32'h1000_0000 + i * 32'h111;
    mem[0] = 32'hFFFF_FFFF;
    mem[5] = 32'hDEAD_BEEF;

    rst       = 1'b1;
    req_valid = 4'b1111;
    req_addr  = '0;
    rsp_ready = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_valid", 64'(rsp_valid), 64'h0);
    chk("rst_sel", 64'(sel), 64'h0);
    chk("rst_id", 64'(rsp_id), 64'h0);
    chk("rst_data", 64'(rsp_data), 64'h0);
    step();
    step();
    rst       = 1'b0;
    req_valid = '0;

    // Single read of x5
    set_addr(0, 5'd5);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    chk("single_gnt", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    #1;
    chk("single_sel", 64'(sel), 64'd5);
    chk("single_noval", 64'(rsp_valid), 64'h0);
    step();
    chk("single_val", 64'(rsp_valid), 64'h1);
    chk("single_id", 64'(rsp_id), 64'h0);
    chk("single_data", 64'(rsp_data), 64'hDEADBEEF);
    step();

    // x0 read from requester 2
    set_addr(2, 5'd0);
    req_valid = 4'b0100;
    #1;
    chk("x0_gnt", 64'(req_ready), 64'h4);
    step();
    req_valid = '0;
    step();
    chk("x0_val", 64'(rsp_valid), 64'h1);
    chk("x0_id", 64'(rsp_id), 64'd2);
    chk("x0_data", 64'(rsp_data), 64'h0);
    step();

    // Reset while in READ
    set_addr(3, 5'd3);
    req_valid = 4'b1000;
    #1;
    chk("rmid_gnt", 64'(req_ready), 64'h8);
    step();
    chk("rmid_sel_pre", 64'(sel), 64'd3);
    req_valid = 4'b1111;
    rst       = 1'b1;
    #1;
    chk("rmid_sel", 64'(sel), 64'h0);
    chk("rmid_val", 64'(rsp_valid), 64'h0);
    chk("rmid_ready", 64'(req_ready), 64'h0);
    chk("rmid_id", 64'(rsp_id), 64'h0);
    step();
    rst       = 1'b0;
    req_valid = '0;
    #1;
    chk("rmid_noval0", 64'(rsp_valid), 64'h0);
    step();
    chk("rmid_noval1", 64'(rsp_valid), 64'h0);

    // Round robin from ptr 0, back-to-back
    for (int i = 0; i < 4; i++)
      set_addr(i, 5'(i + 1));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr_gnt%0d", k),
          64'(req_ready), 64'(1 << (k % 4)));
      if (k > 0) begin
        chk($sformatf("rr_val%0d", k),
            64'(rsp_valid), 64'h1);
        chk($sformatf("rr_id%0d", k),
            64'(rsp_id), 64'((k - 1) % 4));
        chk($sformatf("rr_data%0d", k),
            64'(rsp_data), 64'(mem[(k - 1) % 4 + 1]));
      end
      step();
      chk($sformatf("rr_rd_rdy%0d", k),
          64'(req_ready), 64'h0);
      chk($sformatf("rr_sel%0d", k),
          64'(sel), 64'((k % 4) + 1));
      chk($sformatf("rr_rd_val%0d", k),
          64'(rsp_valid), 64'h0);
      step();
    end
    req_valid = '0;
    #1;
    chk("rr_last_val", 64'(rsp_valid), 64'h1);
    chk("rr_last_id", 64'(rsp_id), 64'h0);
    chk("rr_last_data", 64'(rsp_data), 64'(mem[1]));
    step();

    // Backpressure, ptr now 1
    set_addr(1, 5'd6);
    req_valid = 4'b0010;
    #1;
    chk("bp_gnt", 64'(req_ready), 64'h2);
    step();
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    #1;
    chk("bp_rd_rdy", 64'(req_ready), 64'h0);
    step();
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("bp_val%0d", j), 64'(rsp_valid), 64'h1);
      chk($sformatf("bp_id%0d", j), 64'(rsp_id), 64'h1);
      chk($sformatf("bp_data%0d", j),
          64'(rsp_data), 64'(mem[6]));
      chk($sformatf("bp_rdy%0d", j), 64'(req_ready), 64'h0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_gnt", 64'(req_ready), 64'h4);
    chk("bp_rel_val", 64'(rsp_valid), 64'h1);
    step();
    req_valid = '0;
    #1;
    chk("bp_taken", 64'(rsp_valid), 64'h0);
    chk("bp_sel2", 64'(sel), 64'd3);
    step();
    chk("bp_next_id", 64'(rsp_id), 64'd2);
    chk("bp_next_data", 64'(rsp_data), 64'(mem[3]));
    step();

    // Address hold, ptr now 3
    set_addr(1, 5'd7);
    req_valid = 4'b0010;
    #1;
    chk("ah_gnt", 64'(req_ready), 64'h2);
    step();
    set_addr(1, 5'd9);
    req_valid = '0;
    #1;
    chk("ah_sel_rd", 64'(sel), 64'd7);
    step();
    chk("ah_sel_rsp", 64'(sel), 64'd7);
    chk("ah_id", 64'(rsp_id), 64'h1);
    chk("ah_data", 64'(rsp_data), 64'(mem[7]));
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
